a2d_chnl_sched: RTL
===================

A2D_CHNL_SCHED -- requirements
Module: a2d_chnl_sched

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- nxt  input  1  one-cycle conversion request (driven from INT).
- done  input  1  SPI master transaction-complete pulse.
- rd_data  input  16  SPI master receive word; valid in the cycle done=1.
- wrt  output  1  one-cycle SPI transaction start.
- cmd  output  16  SPI transmit word; held stable from wrt until done.
- lft_ld  output  12  latest left load-cell sample.
- rght_ld  output  12  latest right load-cell sample.
- batt  output  12  latest battery sample.
- upd  output  3  one-cycle update strobe, one-hot: {batt, rght, lft}.
- busy  output  1  high in any state other than IDLE.
- tmo  output  1  one-cycle timeout error pulse.

Function
REQ-002 The block SHALL implement four states: IDLE, CNV, GAP, RD.
REQ-003 The block SHALL keep a rotation pointer. The sequence SHALL be LFT (A2D channel 3'd0), then RGHT (3'd4), then BATT (3'd5), then back to LFT.
REQ-004 In IDLE with nxt=1, the block SHALL assert wrt for one cycle, drive cmd={2'b00, chnl[2:0], 11'h000}, and enter CNV.
REQ-005 In IDLE with nxt=0, the block SHALL hold; done pulses received in IDLE SHALL be ignored.
REQ-006 In CNV, when done=1, the block SHALL enter GAP.
REQ-007 GAP SHALL last exactly one cycle. On exit the block SHALL assert wrt for one cycle, drive cmd=16'h0000, and enter RD.
REQ-008 In RD, when done=1, the block SHALL:
- capture rd_data[11:0] into the output register selected by the pointer;
- pulse the matching upd bit in the next cycle;
- advance the pointer;
- return to IDLE.
REQ-009 The updated sample register SHALL be visible the cycle after the final done. The latency from nxt to upd SHALL therefore be 2 plus both SPI transaction times plus 1 for GAP.
REQ-010 nxt asserted while busy=1 SHALL be dropped. It SHALL NOT be queued.
REQ-011 nxt coinciding with the cycle the block returns to IDLE SHALL be dropped. Only nxt sampled while in IDLE starts a conversion.
REQ-012 A 10-bit watchdog SHALL clear on every entry to CNV or RD and increment each cycle spent in CNV or RD.
REQ-013 When the watchdog reaches 10'd1023 without done, the block SHALL:
- pulse tmo for one cycle;
- return to IDLE;
- leave all sample registers unchanged;
- NOT advance the pointer, so the same channel is retried on the next nxt.
REQ-014 If done arrives in the same cycle the watchdog reaches 1023, done SHALL win: normal transition, no tmo.
REQ-015 Only bits [11:0] of rd_data SHALL be used; bits [15:12] SHALL be ignored.
REQ-016 wrt, upd and tmo SHALL be registered outputs, free of glitches. At most one upd bit SHALL be high in any cycle.

Reset
REQ-017 rst=1 SHALL asynchronously force the following:
- state IDLE and pointer LFT;
- watchdog 0;
- wrt, upd, tmo and busy 0;
- cmd 16'h0000;
- lft_ld and rght_ld 12'h000;
- batt 12'hFFF, so battery-low is not flagged before the first sample.
REQ-018 Reset asserted mid-transaction SHALL abandon the transaction and produce no upd. The first nxt after reset release SHALL sample LFT.

Verification
REQ-019 Single conversion: nxt, done after 20 cycles with rd_data=16'hF123, GAP, done with rd_data=16'hF123 -> cmd 16'h0000 then 16'h0000; lft_ld=12'h123; upd=3'b001.
REQ-020 Rotation: three back-to-back conversions returning 12'h111, 12'h222, 12'h333 -> cmd channel fields 0, 4, 5; lft_ld=12'h111, rght_ld=12'h222, batt=12'h333; upd sequence 001, 010, 100.
REQ-021 Busy drop: nxt pulses during CNV and RD -> no extra wrt; exactly 2 wrt pulses per conversion.
REQ-022 Timeout: nxt with RGHT pending, done never arrives -> tmo pulse 1023 cycles after CNV entry; rght_ld unchanged; next nxt issues cmd channel field 3'd4 again.
REQ-023 Reset mid-RD: rst pulsed during RD -> all outputs take REQ-017 values, batt=12'hFFF, no upd; next nxt addresses channel 0.
REQ-024 Stray done in IDLE, and done coinciding with watchdog=1023 -> no state change for the stray done; normal completion and tmo=0 for the coincident case.

Source files
------------

// File: rtl/a2d_chnl_sched.sv
// A2D channel scheduler: rotates conversions over left, right and battery channels
// using two SPI transactions per sample, with a watchdog on each SPI wait.
module a2d_chnl_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic [2:0]  upd,
  output logic        busy,
  output logic        tmo
);

  typedef enum logic [1:0] {IDLE, CNV, GAP, RD} state_e;
  typedef enum logic [1:0] {LFT, RGHT, BATT} chnl_e;

  state_e      state, state_nxt;
  chnl_e       ptr, ptr_nxt;
  logic [9:0]  wdog, wdog_nxt;
  logic        wrt_nxt, tmo_nxt, cap;
  logic [2:0]  upd_nxt, chnl, sel;
  logic [15:0] cmd_nxt;

  always_comb begin
    chnl = 3'd0;
    sel  = 3'b001;
    case (ptr)
      LFT:     begin chnl = 3'd0; sel = 3'b001; end
      RGHT:    begin chnl = 3'd4; sel = 3'b010; end
      BATT:    begin chnl = 3'd5; sel = 3'b100; end
      default: begin chnl = 3'd0; sel = 3'b001; end
    endcase
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    wdog_nxt  = wdog;
    wrt_nxt   = 1'b0;
    tmo_nxt   = 1'b0;
    upd_nxt   = '0;
    cmd_nxt   = cmd;
    cap       = 1'b0;
    case (state)
      IDLE: begin
        if (nxt) begin
          wrt_nxt   = 1'b1;
          cmd_nxt   = {2'b00, chnl, 11'h000};
          wdog_nxt  = '0;
          state_nxt = CNV;
        end
      end
      CNV: begin
        // done takes priority over an expiring watchdog
        if (done) begin
          state_nxt = GAP;
        end else if (wdog == '1) begin
          tmo_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          wdog_nxt = wdog + 10'd1;
        end
      end
      GAP: begin
        wrt_nxt   = 1'b1;
        cmd_nxt   = '0;
        wdog_nxt  = '0;
        state_nxt = RD;
      end
      RD: begin
        if (done) begin
          cap       = 1'b1;
          upd_nxt   = sel;
          state_nxt = IDLE;
          case (ptr)
            LFT:     ptr_nxt = RGHT;
            RGHT:    ptr_nxt = BATT;
            default: ptr_nxt = LFT;
          endcase
        end else if (wdog == '1) begin
          tmo_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          wdog_nxt = wdog + 10'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= LFT;
      wdog    <= '0;
      wrt     <= 1'b0;
      tmo     <= 1'b0;
      upd     <= '0;
      cmd     <= '0;
      lft_ld  <= '0;
      rght_ld <= '0;
      batt    <= '1;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      wdog  <= wdog_nxt;
      wrt   <= wrt_nxt;
      tmo   <= tmo_nxt;
      upd   <= upd_nxt;
      cmd   <= cmd_nxt;
      if (cap) begin
        case (ptr)
          LFT:     lft_ld  <= rd_data[11:0];
          RGHT:    rght_ld <= rd_data[11:0];
          default: batt    <= rd_data[11:0];
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
